data_break_arbiter: RTL and testbench

//  Shares the single 4Kx12 RAM between the CPU and NREQ data-break (DMA) requesters.

---
 rtl/data_break_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_data_break_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_break_arbiter.sv
// Data-break arbiter: parks the CPU via cpu_hold/cpu_holdack, then serves NREQ requesters
// round-robin on the shared 4Kx12 RAM. Optional increment-memory break: DB_INCMEM_EN.
module data_break_arbiter #(
  parameter int NREQ     = 2,
  parameter int MAXBURST = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     wr,
  input  logic [NREQ*12-1:0]  addr,
  input  logic [NREQ*12-1:0]  wdata,
`ifdef DB_INCMEM_EN
  input  logic [NREQ-1:0]     inc,
  output logic                ovf,
`endif
  output logic [NREQ-1:0]     gnt,
  output logic [11:0]         rdata,
  output logic                cpu_hold,
  input  logic                cpu_holdack,
  output logic [11:0]         ram_addr,
  output logic [11:0]         ram_dout,
  input  logic [11:0]         ram_din,
  output logic                ram_oe,
  output logic                ram_we,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE, WAIT_ACK, SELECT, ACC1, ACC2, DONE, RELEASE
`ifdef DB_INCMEM_EN
    , INC_WR
`endif
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  rr_reg, idx_reg, sel_idx, rr_next_val;
  logic [3:0]  burst_reg;
  logic [11:0] addr_reg, wdata_reg, rdata_reg;
  logic        wr_reg, is_write, drive;
  logic [3:0]  req_ext, wr_ext, hi_mask, req_hi, cand, idx_onehot;
  logic [11:0] addr_arr [4];
  logic [11:0] wdata_arr [4];
  logic        pending, burst_ok;
`ifdef DB_INCMEM_EN
  logic [3:0]  inc_ext;
  logic        inc_reg, ovf_reg;
`endif

  // Requester lanes padded to four so indices are always 2 bits wide.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      if (gi < NREQ) begin : g_used
        assign req_ext[gi]   = req[gi];
        assign wr_ext[gi]    = wr[gi];
        assign addr_arr[gi]  = addr[12*gi +: 12];
        assign wdata_arr[gi] = wdata[12*gi +: 12];
`ifdef DB_INCMEM_EN
        assign inc_ext[gi]   = inc[gi];
`endif
      end else begin : g_unused
        assign req_ext[gi]   = 1'b0;
        assign wr_ext[gi]    = 1'b0;
        assign addr_arr[gi]  = 12'd0;
        assign wdata_arr[gi] = 12'd0;
`ifdef DB_INCMEM_EN
        assign inc_ext[gi]   = 1'b0;
`endif
      end
      assign hi_mask[gi] = (2'(gi) >= rr_reg);
    end
  endgenerate

  // Round-robin: lowest request at/above rr, else wrap to lowest overall.
  always_comb begin
    req_hi  = req_ext & hi_mask;
    cand    = (|req_hi) ? req_hi : req_ext;
    sel_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (cand[k]) sel_idx = 2'(k);
    end
  end

  assign idx_onehot  = 4'b0001 << idx_reg;
  assign pending     = |(req_ext & ~idx_onehot);
  assign burst_ok    = (burst_reg + 4'd1) < 4'(MAXBURST);
  assign rr_next_val = (idx_reg == 2'(NREQ - 1)) ? 2'd0 : idx_reg + 2'd1;
`ifdef DB_INCMEM_EN
  assign is_write    = wr_reg & ~inc_reg;
`else
  assign is_write    = wr_reg;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rr_reg    <= 2'd0;
      idx_reg   <= 2'd0;
      burst_reg <= 4'd0;
      addr_reg  <= 12'd0;
      wdata_reg <= 12'd0;
      rdata_reg <= 12'd0;
      wr_reg    <= 1'b0;
`ifdef DB_INCMEM_EN
      inc_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        SELECT: begin
          idx_reg   <= sel_idx;
          addr_reg  <= addr_arr[sel_idx];
          wdata_reg <= wdata_arr[sel_idx];
          wr_reg    <= wr_ext[sel_idx];
`ifdef DB_INCMEM_EN
          inc_reg   <= inc_ext[sel_idx];
          ovf_reg   <= 1'b0;
`endif
        end
        ACC2: if (!is_write) rdata_reg <= ram_din;
`ifdef DB_INCMEM_EN
        INC_WR: begin
          rdata_reg <= rdata_reg + 12'd1;
          ovf_reg   <= &rdata_reg;
        end
`endif
        DONE: begin
          rr_reg    <= rr_next_val;
          burst_reg <= burst_reg + 4'd1;
        end
        RELEASE: burst_reg <= 4'd0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    cpu_hold   = 1'b0;
    drive      = 1'b0;
    ram_we     = 1'b0;
    ram_dout   = 12'd0;
    case (state_reg)
      IDLE:     if (|req_ext) state_next = WAIT_ACK;
      WAIT_ACK: begin
        cpu_hold = 1'b1;
        if (cpu_holdack) state_next = (|req_ext) ? SELECT : RELEASE;
      end
      SELECT: begin
        cpu_hold   = 1'b1;
        state_next = (|req_ext) ? ACC1 : RELEASE;
      end
      ACC1: begin
        cpu_hold   = 1'b1;
        drive      = 1'b1;
        state_next = ACC2;
      end
      ACC2: begin
        cpu_hold   = 1'b1;
        drive      = 1'b1;
        state_next = DONE;
`ifdef DB_INCMEM_EN
        if (inc_reg) state_next = INC_WR;
`endif
      end
`ifdef DB_INCMEM_EN
      INC_WR: begin
        cpu_hold   = 1'b1;
        ram_we     = 1'b1;
        ram_dout   = rdata_reg + 12'd1;
        state_next = DONE;
      end
`endif
      DONE: begin
        cpu_hold   = 1'b1;
        state_next = (pending && burst_ok) ? SELECT : RELEASE;
      end
      RELEASE:  if (!cpu_holdack) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (drive && is_write) begin
      ram_we   = 1'b1;
      ram_dout = wdata_reg;
    end
  end

`ifdef DB_INCMEM_EN
  assign ram_addr = (drive || state_reg == INC_WR) ? addr_reg : 12'd0;
  assign ovf      = (state_reg == DONE) & ovf_reg;
`else
  assign ram_addr = drive ? addr_reg : 12'd0;
`endif
  assign ram_oe = drive & ~is_write;
  assign gnt    = (state_reg == DONE) ? idx_onehot[NREQ-1:0] : '0;
  assign rdata  = rdata_reg;
  assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_data_break_arbiter.sv
// Scoreboard bench for data_break_arbiter: directed requests push expected grants,
// a negedge monitor pops and compares on every gnt.
module tb_data_break_arbiter;
  localparam int NREQ = 2;
  localparam int MAXBURST = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  req, wr;
  logic [23:0] addr, wdata;
  logic [1:0]  gnt;
  logic [11:0] rdata, ram_addr, ram_dout, ram_din;
  logic        cpu_hold, cpu_holdack, ram_oe, ram_we, busy;
`ifdef DB_INCMEM_EN
  logic [1:0]  inc;
  logic        ovf;
`endif

  data_break_arbiter #(.NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
`ifdef DB_INCMEM_EN
    .inc(inc), .ovf(ovf),
`endif
    .gnt(gnt), .rdata(rdata), .cpu_hold(cpu_hold), .cpu_holdack(cpu_holdack),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din),
    .ram_oe(ram_oe), .ram_we(ram_we), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // RAM model with asynchronous read and a preload port.
  logic [11:0] mem [0:4095];
  logic        preload_en = 1'b0;
  logic [11:0] preload_addr, preload_val;
  assign ram_din = ram_oe ? mem[ram_addr] : 12'd0;
  always @(posedge CLK) begin
    if (preload_en) mem[preload_addr] <= preload_val;
    else if (ram_we) mem[ram_addr] <= ram_dout;
  end

  // CPU model: holdack follows cpu_hold two cycles later.
  logic hd1, hd2;
  always @(posedge CLK) begin
    if (RESET) begin
      hd1 <= 1'b0;
      hd2 <= 1'b0;
    end else begin
      hd1 <= cpu_hold;
      hd2 <= hd1;
    end
  end
  assign cpu_holdack = hd2;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic        chk_rd;
    logic [11:0] rd;
    logic        ovf;
    int          oe_n;
    int          we_n;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_cycs[$];
  int   errors = 0;
  int   checks = 0;
  int   hold_rises = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0o required %0o (t=%0t)", name, act, req_v, $time);
    end
  endtask

  function automatic exp_t mk(input int i, input logic c, input logic [11:0] r,
                              input logic o, input int oe_n, input int we_n);
    exp_t e;
    e.idx = i; e.chk_rd = c; e.rd = r; e.ovf = o; e.oe_n = oe_n; e.we_n = we_n;
    return e;
  endfunction

  // Monitor
  initial begin
    int   oe_n = 0;
    int   we_n = 0;
    logic hold_d = 1'b0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        oe_n = 0;
        we_n = 0;
      end else begin
        if (ram_oe) oe_n++;
        if (ram_we) we_n++;
        if (cpu_hold && !hold_d) hold_rises++;
        if (gnt != 2'b00) begin
          gnt_cycs.push_back(cyc);
          $display("gnt=%b rdata=%04o cyc=%0d", gnt, rdata, cyc);
          if (exp_q.size() == 0) begin
            check("unexpected_gnt", 32'(gnt), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("gnt_vec", 32'(gnt), 32'(2'b01 << e.idx));
            if (e.chk_rd) check("rdata", 32'(rdata), 32'(e.rd));
            check("oe_cycles", 32'(oe_n), 32'(e.oe_n));
            check("we_cycles", 32'(we_n), 32'(e.we_n));
`ifdef DB_INCMEM_EN
            check("ovf", 32'(ovf), 32'(e.ovf));
`endif
          end
          oe_n = 0;
          we_n = 0;
        end
      end
      hold_d = cpu_hold;
    end
  end

  task automatic poke(input logic [11:0] a, input logic [11:0] v);
    @(posedge CLK); #1;
    preload_addr = a; preload_val = v; preload_en = 1'b1;
    @(posedge CLK); #1;
    preload_en = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  // Raise req[i] n times, each held until gnt and dropped in the following cycle.
  task automatic do_req(input int i, input logic w, input logic [11:0] a, input logic [11:0] d,
                        input int n, input logic incv);
    for (int t = 0; t < n; t++) begin
      bit ok = 0;
      wr[i] = w;
      addr[12*i +: 12] = a;
      wdata[12*i +: 12] = d;
`ifdef DB_INCMEM_EN
      inc[i] = incv;
`endif
      req[i] = 1'b1;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge CLK);
        if (gnt[i]) ok = 1;
      end
      check("gnt_timeout", 32'(ok), 32'd1);
      @(posedge CLK); #1;
      req[i] = 1'b0;
      if (t < n - 1) begin
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(posedge CLK); #1;
      if (!busy && !cpu_holdack) ok = 1;
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    int t0;
    int hr0;
    int n;
    bit seen;
    RESET = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0;
`ifdef DB_INCMEM_EN
    inc = '0;
`endif
    repeat (3) @(posedge CLK);
    #1;
    check("rst_cpu_hold", 32'(cpu_hold), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_ram_oe", 32'(ram_oe), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_rdata", 32'(rdata), 0);
    RESET = 1'b0;

    // 1: write, holdack 2 cycles after hold -> latency 1+2+4
    exp_q.push_back(mk(0, 1'b0, 12'o0, 1'b0, 0, 2));
    t0 = cyc;
    do_req(0, 1'b1, 12'o0200, 12'o1234, 1, 1'b0);
    check("t1_latency", 32'(gnt_cycs[gnt_cycs.size()-1] - t0), 32'd7);
    wait_idle();
    check("t1_mem0200", 32'(mem[12'o0200]), 32'o1234);
    check("t1_hold_dropped", 32'(cpu_hold), 0);

    // 2: read
    poke(12'o0300, 12'o4321);
    exp_q.push_back(mk(1, 1'b1, 12'o4321, 1'b0, 2, 0));
    do_req(1, 1'b0, 12'o0300, 12'o0, 1, 1'b0);
    wait_idle();

    // 3: simultaneous requests from reset, one hold, 4 cycles apart
    do_reset();
    hr0 = hold_rises;
    exp_q.push_back(mk(0, 1'b0, 12'o0, 1'b0, 0, 2));
    exp_q.push_back(mk(1, 1'b1, 12'o1234, 1'b0, 2, 0));
    fork
      do_req(0, 1'b1, 12'o0500, 12'o1111, 1, 1'b0);
      do_req(1, 1'b0, 12'o0200, 12'o0, 1, 1'b0);
    join
    wait_idle();
    n = gnt_cycs.size();
    check("t3_gap", 32'(gnt_cycs[n-1] - gnt_cycs[n-2]), 32'd4);
    check("t3_hold_rises", 32'(hold_rises - hr0), 32'd1);

    // 4: burst limit 2 -> release, hold re-raised, third grant
    hr0 = hold_rises;
    exp_q.push_back(mk(0, 1'b0, 12'o0, 1'b0, 0, 2));
    exp_q.push_back(mk(1, 1'b1, 12'o1111, 1'b0, 2, 0));
    exp_q.push_back(mk(0, 1'b0, 12'o0, 1'b0, 0, 2));
    fork
      do_req(0, 1'b1, 12'o0600, 12'o2222, 2, 1'b0);
      do_req(1, 1'b0, 12'o0500, 12'o0, 1, 1'b0);
    join
    wait_idle();
    n = gnt_cycs.size();
    check("t4_gap_burst", 32'(gnt_cycs[n-2] - gnt_cycs[n-3]), 32'd4);
    check("t4_gap_release", 32'(gnt_cycs[n-1] - gnt_cycs[n-2]), 32'd11);
    check("t4_hold_rises", 32'(hold_rises - hr0), 32'd2);
    check("t4_mem0600", 32'(mem[12'o0600]), 32'o2222);

    // 5: reset during ACC1 of a write
    wr[0] = 1'b1; addr[11:0] = 12'o0700; wdata[11:0] = 12'o3333; req[0] = 1'b1;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge CLK);
      if (ram_we) seen = 1;
    end
    check("t5_reached_acc1", 32'(seen), 32'd1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    check("t5_cpu_hold", 32'(cpu_hold), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_ram_we", 32'(ram_we), 0);
    check("t5_ram_addr", 32'(ram_addr), 0);
    check("t5_ram_dout", 32'(ram_dout), 0);
    check("t5_gnt", 32'(gnt), 0);
    req = '0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("t5_still_idle", 32'(busy), 0);

`ifdef DB_INCMEM_EN
    // 6: increment-memory break
    poke(12'o0010, 12'o7777);
    exp_q.push_back(mk(0, 1'b1, 12'o0000, 1'b1, 2, 1));
    do_req(0, 1'b0, 12'o0010, 12'o0, 1, 1'b1);
    wait_idle();
    check("t6_mem_wrap", 32'(mem[12'o0010]), 32'o0000);
    poke(12'o0010, 12'o0005);
    exp_q.push_back(mk(0, 1'b1, 12'o0006, 1'b0, 2, 1));
    do_req(0, 1'b0, 12'o0010, 12'o0, 1, 1'b1);
    wait_idle();
    check("t6_mem_inc", 32'(mem[12'o0010]), 32'o0006);
    inc = '0;
`endif

    repeat (5) @(posedge CLK);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
